// File: rtl/sprite_cmd_if.sv
// Command handshake bus between a sprite command source and sprite_cmd_driver.
interface sprite_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_sync;
  logic [4:0]  cmd_sprite;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [0:0]  cmd_vis;
  logic [1:0]  cmd_bg;
  logic [3:0]  cmd_fill;
  logic [10:0] cmd_base;
  logic [10:0] cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_sync, cmd_sprite, cmd_x, cmd_y,
           cmd_vis, cmd_bg, cmd_fill, cmd_base, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sync, cmd_sprite, cmd_x, cmd_y,
           cmd_vis, cmd_bg, cmd_fill, cmd_base, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/sprite_cmd_driver.sv
// Turns queued sprite/background/fill commands into timed strobes for the display core,
// optionally deferring each command to the next vsync falling edge.
module sprite_cmd_driver #(
  parameter int unsigned HOLD_CYCLES = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  sprite_cmd_if.slave cmd,
  input  logic        vsync,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        visable,
  output logic        load_pos,
  output logic        load_att,
  output logic [4:0]  sprite_sel,
  output logic        bchange_active,
  output logic [1:0]  background_sel,
  output logic        fchange_active,
  output logic [3:0]  fwdata,
  output logic [10:0] fwaddr,
  output logic        fwenable,
  output logic        busy,
  output logic        cmd_err
);

  localparam int unsigned CNT_W = 11;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_POS = 3'd1;
  localparam logic [2:0] OP_SET_ATT = 3'd2;
  localparam logic [2:0] OP_BG_CHG  = 3'd3;
  localparam logic [2:0] OP_FILL    = 3'd4;
  localparam logic [2:0] OP_F_CHG   = 3'd5;

  typedef enum logic [2:0] {
    IDLE, WAIT_VS, ISSUE, HOLD, FILL, GAP
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  sprite;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        vis;
    logic [1:0]  bg;
    logic [3:0]  fill;
    logic [10:0] base;
    logic [10:0] len;
  } cmd_t;

  state_t                 state;
  cmd_t                   r;
  logic [CNT_W-1:0]       cnt;
  logic                   ready_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   vs_prev;
  logic                   vs_fall_c;

  assign cmd.cmd_ready = ready_q;
  assign vs_fall_c     = vs_prev & ~sync_q[SYNC_STAGES-1];

  // Strobes are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      r              <= '0;
      cnt            <= '0;
      ready_q        <= 1'b0;
      sync_q         <= '1;
      vs_prev        <= 1'b1;
      x              <= '0;
      y              <= '0;
      visable        <= 1'b0;
      load_pos       <= 1'b0;
      load_att       <= 1'b0;
      sprite_sel     <= '0;
      bchange_active <= 1'b0;
      background_sel <= '0;
      fchange_active <= 1'b0;
      fwdata         <= '0;
      fwaddr         <= '0;
      fwenable       <= 1'b0;
      busy           <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      sync_q[0] <= vsync;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      vs_prev <= sync_q[SYNC_STAGES-1];

      load_pos       <= 1'b0;
      load_att       <= 1'b0;
      bchange_active <= 1'b0;
      fchange_active <= 1'b0;
      fwenable       <= 1'b0;
      cmd_err        <= 1'b0;

      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          if (cmd.cmd_valid && ready_q) begin
            r.op     <= cmd.cmd_op;
            r.sprite <= cmd.cmd_sprite;
            r.x      <= cmd.cmd_x;
            r.y      <= cmd.cmd_y;
            r.vis    <= cmd.cmd_vis[0];
            r.bg     <= cmd.cmd_bg;
            r.fill   <= cmd.cmd_fill;
            r.base   <= cmd.cmd_base;
            r.len    <= cmd.cmd_len;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            state    <= cmd.cmd_sync ? WAIT_VS : ISSUE;
          end
        end

        // vs_prev makes a level that is already low on entry invisible.
        WAIT_VS: if (vs_fall_c) state <= ISSUE;

        ISSUE: begin
          case (r.op)
            OP_NOP: state <= GAP;
            OP_SET_POS: begin
              x          <= r.x;
              y          <= r.y;
              sprite_sel <= r.sprite;
              load_pos   <= 1'b1;
              state      <= GAP;
            end
            OP_SET_ATT: begin
              visable    <= r.vis;
              sprite_sel <= r.sprite;
              load_att   <= 1'b1;
              state      <= GAP;
            end
            OP_BG_CHG: begin
              background_sel <= r.bg;
              bchange_active <= 1'b1;
              cnt            <= CNT_W'(HOLD_CYCLES - 1);
              state          <= HOLD;
            end
            OP_F_CHG: begin
              fchange_active <= 1'b1;
              cnt            <= CNT_W'(HOLD_CYCLES - 1);
              state          <= HOLD;
            end
            OP_FILL: begin
              fwenable <= 1'b1;
              fwdata   <= r.fill;
              fwaddr   <= r.base;
              cnt      <= r.len;
              state    <= (r.len == '0) ? GAP : FILL;
            end
            default: begin
              cmd_err <= 1'b1;
              state   <= GAP;
            end
          endcase
        end

        HOLD: begin
          if (r.op == OP_BG_CHG) bchange_active <= 1'b1;
          else                   fchange_active <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= GAP;
        end

        // 11-bit address wraps naturally from 2047 to 0.
        FILL: begin
          fwenable <= 1'b1;
          fwaddr   <= fwaddr + 11'd1;
          cnt      <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= GAP;
        end

        GAP: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_cmd_driver.sv
// Directed bench for sprite_cmd_driver; cycle c1 is the cycle right after the accepting edge.
module tb_sprite_cmd_driver;

  logic        clk_100mhz = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        visable, load_pos, load_att;
  logic [4:0]  sprite_sel;
  logic        bchange_active, fchange_active;
  logic [1:0]  background_sel;
  logic [3:0]  fwdata;
  logic [10:0] fwaddr;
  logic        fwenable, busy, cmd_err;

  int total = 0;
  int bad   = 0;

  sprite_cmd_if ci ();

  sprite_cmd_driver #(.HOLD_CYCLES(6), .SYNC_STAGES(2)) dut (
    .clk_100mhz     (clk_100mhz),
    .rst_n          (rst_n),
    .cmd            (ci.slave),
    .vsync          (vsync),
    .x              (x),
    .y              (y),
    .visable        (visable),
    .load_pos       (load_pos),
    .load_att       (load_att),
    .sprite_sel     (sprite_sel),
    .bchange_active (bchange_active),
    .background_sel (background_sel),
    .fchange_active (fchange_active),
    .fwdata         (fwdata),
    .fwaddr         (fwaddr),
    .fwenable       (fwenable),
    .busy           (busy),
    .cmd_err        (cmd_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic clear_fields();
    ci.cmd_op = 3'd0; ci.cmd_sync = 1'b0; ci.cmd_sprite = '0; ci.cmd_x = '0;
    ci.cmd_y = '0; ci.cmd_vis = '0; ci.cmd_bg = '0; ci.cmd_fill = '0;
    ci.cmd_base = '0; ci.cmd_len = '0;
  endtask

  // Raise valid, wait (bounded) for ready, let one edge accept, drop valid; returns in c1.
  task automatic send();
    int n = 0;
    ci.cmd_valid = 1'b1;
    while (ci.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (ci.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL send_ready_timeout: got cmd_ready=%b want 1", ci.cmd_ready);
    end
    tick();
    ci.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; ci.cmd_valid = 1'b0; clear_fields();
    #22;
    total++;
    if ({ci.cmd_ready, busy, load_pos, fwenable, cmd_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {ci.cmd_ready, busy, load_pos, fwenable, cmd_err});
    end
    total++;
    if ({x, y, fwaddr, sprite_sel} !== 35'd0) begin
      bad++; $display("FAIL reset_data: got x=%0d y=%0d addr=%0d spr=%0d want 0", x, y, fwaddr, sprite_sel);
    end
    @(negedge clk_100mhz) rst_n = 1'b1;
    #1;
    total++;
    if (ci.cmd_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_clock: got %b want 0", ci.cmd_ready);
    end
    tick();
    total++;
    if (ci.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_clock: got %b want 1", ci.cmd_ready);
    end
  endtask

  task automatic test_set_pos();
    clear_fields();
    ci.cmd_op = 3'd1; ci.cmd_x = 10'd320; ci.cmd_y = 9'd240; ci.cmd_sprite = 5'd7;
    send();
    total++;
    if ({load_pos, busy, ci.cmd_ready} !== 3'b010) begin
      bad++; $display("FAIL setpos_c1: got lp/busy/rdy=%b want 010", {load_pos, busy, ci.cmd_ready});
    end
    tick();
    total++;
    if (load_pos !== 1'b1 || x !== 10'd320 || y !== 9'd240 || sprite_sel !== 5'd7) begin
      bad++; $display("FAIL setpos_c2: got lp=%b x=%0d y=%0d spr=%0d want 1 320 240 7", load_pos, x, y, sprite_sel);
    end
    tick();
    total++;
    if (load_pos !== 1'b0 || ci.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL setpos_c3: got lp=%b rdy=%b want 0 1", load_pos, ci.cmd_ready);
    end
  endtask

  // Shared observation of a HOLD_CYCLES=6 change strobe for bg (is_bg=1) or frame change.
  task automatic test_change(input bit is_bg);
    int first = -1, cnt = 0, rdy_at = -1;
    bit other = 0, sel_bad = 0;
    clear_fields();
    ci.cmd_op = is_bg ? 3'd3 : 3'd5; ci.cmd_bg = 2'd2;
    send();
    for (int k = 1; k <= 12; k++) begin
      logic s, o;
      s = is_bg ? bchange_active : fchange_active;
      o = is_bg ? fchange_active : bchange_active;
      if (s) begin
        if (first < 0) first = k;
        cnt++;
        if (is_bg && background_sel !== 2'd2) sel_bad = 1;
      end
      if (o) other = 1;
      if (ci.cmd_ready === 1'b1 && rdy_at < 0) rdy_at = k;
      tick();
    end
    total++;
    if (first != 2 || cnt != 6) begin
      bad++; $display("FAIL change%0d_window: got first=%0d count=%0d want 2 6", is_bg, first, cnt);
    end
    total++;
    if (other || sel_bad) begin
      bad++; $display("FAIL change%0d_side: got other=%0b selbad=%0b want 0 0", is_bg, other, sel_bad);
    end
    total++;
    if (rdy_at != 8) begin
      bad++; $display("FAIL change%0d_ready: got cycle %0d want 8", is_bg, rdy_at);
    end
  endtask

  task automatic test_fill_wrap();
    clear_fields();
    ci.cmd_op = 3'd4; ci.cmd_base = 11'd2046; ci.cmd_len = 11'd3; ci.cmd_fill = 4'hA;
    send();
    for (int k = 1; k <= 7; k++) begin
      logic        en;
      logic [10:0] ea;
      en = (k >= 2 && k <= 5);
      ea = 11'(2046 + k - 2);
      total++;
      if (fwenable !== en) begin
        bad++; $display("FAIL fill_en_c%0d: got %b want %b", k, fwenable, en);
      end
      if (en) begin
        total++;
        if (fwaddr !== ea || fwdata !== 4'hA) begin
          bad++; $display("FAIL fill_word_c%0d: got addr=%0d data=%h want %0d a", k, fwaddr, fwdata, ea);
        end
      end
      if (k == 6) begin
        total++;
        if (ci.cmd_ready !== 1'b1) begin
          bad++; $display("FAIL fill_ready: got %b want 1", ci.cmd_ready);
        end
      end
      tick();
    end
    total++;
    if (x !== 10'd320) begin
      bad++; $display("FAIL data_hold: got x=%0d want 320", x);
    end
  endtask

  task automatic test_sync_att();
    int n = 0;
    bit early = 0;
    clear_fields();
    vsync = 1'b0;
    repeat (5) tick();
    ci.cmd_op = 3'd2; ci.cmd_sync = 1'b1; ci.cmd_vis = 1'b1; ci.cmd_sprite = 5'd3;
    send();
    repeat (8) begin if (load_att) early = 1; tick(); end
    vsync = 1'b1;
    repeat (6) begin if (load_att) early = 1; tick(); end
    total++;
    if (early || busy !== 1'b1) begin
      bad++; $display("FAIL sync_no_early: got early=%0b busy=%b want 0 1", early, busy);
    end
    vsync = 1'b0;
    while (load_att !== 1'b1 && n < 12) begin tick(); n++; end
    // Four edges: two sync stages, edge detect, then the registered strobe.
    total++;
    if (n != 4) begin
      bad++; $display("FAIL sync_latency: got %0d edges want 4", n);
    end
    total++;
    if (visable !== 1'b1 || sprite_sel !== 5'd3) begin
      bad++; $display("FAIL sync_att_data: got vis=%b spr=%0d want 1 3", visable, sprite_sel);
    end
    tick();
    total++;
    if (load_att !== 1'b0) begin
      bad++; $display("FAIL sync_att_width: got %b want 0", load_att);
    end
  endtask

  task automatic test_illegal();
    clear_fields();
    ci.cmd_op = 3'd7;
    send();
    total++;
    if (cmd_err !== 1'b0) begin
      bad++; $display("FAIL illegal_c1: got err=%b want 0", cmd_err);
    end
    tick();
    total++;
    if ({cmd_err, load_pos, load_att, bchange_active, fchange_active, fwenable} !== 6'b100000) begin
      bad++; $display("FAIL illegal_c2: got %b want 100000",
                      {cmd_err, load_pos, load_att, bchange_active, fchange_active, fwenable});
    end
    tick();
    total++;
    if (cmd_err !== 1'b0 || ci.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_c3: got err=%b rdy=%b want 0 1", cmd_err, ci.cmd_ready);
    end
  endtask

  task automatic test_reset_mid_fill();
    clear_fields();
    ci.cmd_op = 3'd4; ci.cmd_base = 11'd5; ci.cmd_len = 11'd10; ci.cmd_fill = 4'h3;
    send();
    repeat (3) tick();
    total++;
    if (fwenable !== 1'b1 || fwaddr !== 11'd7) begin
      bad++; $display("FAIL midfill_pre: got en=%b addr=%0d want 1 7", fwenable, fwaddr);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({fwenable, busy, ci.cmd_ready, fwaddr, fwdata, x} !== 28'd0) begin
      bad++; $display("FAIL midfill_reset: got en=%b busy=%b addr=%0d x=%0d want 0", fwenable, busy, fwaddr, x);
    end
    @(negedge clk_100mhz) rst_n = 1'b1;
    tick();
    clear_fields();
    ci.cmd_op = 3'd1; ci.cmd_x = 10'd100; ci.cmd_y = 9'd50; ci.cmd_sprite = 5'd2;
    send();
    tick();
    total++;
    if (load_pos !== 1'b1 || x !== 10'd100 || y !== 9'd50 || sprite_sel !== 5'd2 || fwenable !== 1'b0) begin
      bad++; $display("FAIL post_reset_cmd: got lp=%b x=%0d y=%0d spr=%0d en=%b want 1 100 50 2 0",
                      load_pos, x, y, sprite_sel, fwenable);
    end
    tick();
  endtask

  // Valid stays high across two commands; fields changed while busy must not leak into the first.
  task automatic test_back_to_back();
    int pulses = 0;
    clear_fields();
    vsync = 1'b1;
    ci.cmd_op = 3'd1; ci.cmd_x = 10'd1; ci.cmd_y = 9'd11; ci.cmd_sprite = 5'd1;
    send();
    ci.cmd_valid = 1'b1;
    ci.cmd_x = 10'd2; ci.cmd_y = 9'd22; ci.cmd_sprite = 5'd4;
    for (int k = 1; k <= 9; k++) begin
      if (load_pos) pulses++;
      if (k == 2) begin
        total++;
        if (load_pos !== 1'b1 || x !== 10'd1 || y !== 9'd11) begin
          bad++; $display("FAIL b2b_first: got lp=%b x=%0d y=%0d want 1 1 11", load_pos, x, y);
        end
      end
      if (k == 3) begin
        total++;
        if (ci.cmd_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_ready: got %b want 1", ci.cmd_ready);
        end
      end
      if (k == 5) begin
        total++;
        if (load_pos !== 1'b1 || x !== 10'd2 || sprite_sel !== 5'd4) begin
          bad++; $display("FAIL b2b_second: got lp=%b x=%0d spr=%0d want 1 2 4", load_pos, x, sprite_sel);
        end
      end
      tick();
      if (k == 3) ci.cmd_valid = 1'b0;
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL b2b_count: got %0d pulses want 2", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_set_pos();
    test_change(1'b1);
    test_change(1'b0);
    test_fill_wrap();
    test_sync_att();
    test_illegal();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
